// File: rtl/bin_morph_3x3.sv
// 3x3 binary erode/dilate over a streamed window, with frame-border forcing and
// a per-frame mode latch. Two register stages from window to output.
module bin_morph_3x3 #(
    parameter int   IMG_W      = 800,
    parameter int   IMG_H      = 480,
    parameter logic BORDER_VAL = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic matrix_wr_en,
    input  logic matrix_p11,
    input  logic matrix_p12,
    input  logic matrix_p13,
    input  logic matrix_p21,
    input  logic matrix_p22,
    input  logic matrix_p23,
    input  logic matrix_p31,
    input  logic matrix_p32,
    input  logic matrix_p33,
    input  logic mode_sel,
    output logic out_en,
    output logic out_bit,
    output logic frame_done
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    // Handshake: matrix_wr_en is a valid with no ready; every cycle it is high
    // one window is consumed, and exactly one out_en follows two cycles later.

    logic [8:0]       window;
    logic             window_and;
    logic             window_or;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             mode_q;
    logic             first_px;
    logic             last_col;
    logic             last_row;
    logic             mode_eff;
    logic             border_px;

    logic s1_valid;
    logic s1_and;
    logic s1_or;
    logic s1_mode;
    logic s1_border;
    logic s1_last;
    logic s1_result;

    always_comb begin
        window     = {matrix_p11, matrix_p12, matrix_p13,
                      matrix_p21, matrix_p22, matrix_p23,
                      matrix_p31, matrix_p32, matrix_p33};
        window_and = &window;
        window_or  = |window;
        first_px   = (col == '0) && (row == '0);
        last_col   = (col == COL_LAST);
        last_row   = (row == ROW_LAST);
        border_px  = (col == '0) || last_col || (row == '0) || last_row;
        // The first pixel of a frame already uses the freshly sampled mode.
        mode_eff   = first_px ? mode_sel : mode_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            col    <= '0;
            row    <= '0;
            mode_q <= 1'b0;
        end else if (matrix_wr_en) begin
            if (first_px) begin
                mode_q <= mode_sel;
            end
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_valid  <= 1'b0;
            s1_and    <= 1'b0;
            s1_or     <= 1'b0;
            s1_mode   <= 1'b0;
            s1_border <= 1'b0;
            s1_last   <= 1'b0;
        end else begin
            s1_valid <= matrix_wr_en;
            if (matrix_wr_en) begin
                s1_and    <= window_and;
                s1_or     <= window_or;
                s1_mode   <= mode_eff;
                s1_border <= border_px;
                s1_last   <= last_col && last_row;
            end
        end
    end

    always_comb begin
        s1_result = 1'b0;
        if (s1_border) begin
            s1_result = BORDER_VAL;
        end else if (s1_mode) begin
            s1_result = s1_or;
        end else begin
            s1_result = s1_and;
        end
    end

    // out_bit only moves on a valid result so it holds between pixels.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_en     <= 1'b0;
            out_bit    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_en     <= s1_valid;
            frame_done <= s1_valid && s1_last;
            if (s1_valid) begin
                out_bit <= s1_result;
            end
        end
    end

endmodule

// File: tb/tb_bin_morph_3x3.sv
// Bench for bin_morph_3x3 on an 8x4 frame: table vectors, directed sequences and
// random gapped traffic scored against a position-based reference model.
module tb_bin_morph_3x3;

    localparam int IMG_W = 8;
    localparam int IMG_H = 4;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int W     = 34;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic matrix_wr_en = 1'b0;
    logic [8:0] win = '0;
    logic mode_sel = 1'b0;
    logic out_en;
    logic out_bit;
    logic frame_done;

    bin_morph_3x3 #(.IMG_W(IMG_W), .IMG_H(IMG_H), .BORDER_VAL(1'b0)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .matrix_wr_en(matrix_wr_en),
        .matrix_p11(win[8]), .matrix_p12(win[7]), .matrix_p13(win[6]),
        .matrix_p21(win[5]), .matrix_p22(win[4]), .matrix_p23(win[3]),
        .matrix_p31(win[2]), .matrix_p32(win[1]), .matrix_p33(win[0]),
        .mode_sel(mode_sel), .out_en(out_en), .out_bit(out_bit), .frame_done(frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    logic [31:0] cyc = '0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    int m_idx = 0;
    logic m_mode = 1'b0;
    logic last_bit = 1'b0;
    int n_en = 0, n_one = 0, n_fd = 0;

    // Reference: pixel position from a running index; result from the frame's mode.
    task automatic drive(input logic [8:0] bits, input logic m);
        int c, r;
        logic res, eb, fd;
        c = m_idx % IMG_W;
        r = m_idx / IMG_W;
        if (m_idx == 0) m_mode = m;
        res = m_mode ? (bits != 9'd0) : (bits == 9'h1ff);
        eb  = (c == 0 || c == IMG_W-1 || r == 0 || r == IMG_H-1) ? 1'b0 : res;
        fd  = (m_idx == NPIX-1);
        exp_q.push_back({cyc + 32'd2, fd, eb});
        m_idx = (m_idx + 1) % NPIX;
        win = bits;
        mode_sel = m;
        matrix_wr_en = 1'b1;
        @(negedge sys_clk);
        matrix_wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        matrix_wr_en = 1'b0;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic do_reset();
        #2;
        sys_rst_n = 1'b0;
        matrix_wr_en = 1'b0;
        exp_q.delete();
        m_idx = 0;
        m_mode = 1'b0;
        #1;
        check("rst_out_en", {31'd0, out_en}, 0);
        check("rst_out_bit", {31'd0, out_bit}, 0);
        check("rst_frame_done", {31'd0, frame_done}, 0);
        last_bit = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            idle(1);
            k++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (out_en) begin
                logic [W-1:0] e;
                n_en++;
                if (out_bit) n_one++;
                if (frame_done) n_fd++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out_en cyc=%0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ({cyc, frame_done, out_bit} !== e) begin
                        errors++;
                        $display("FAIL pixel cyc/fd/bit actual=%0d/%0b/%0b required=%0d/%0b/%0b",
                                 cyc, frame_done, out_bit, e[W-1:2], e[1], e[0]);
                    end
                end
            end else begin
                checks++;
                if (frame_done !== 1'b0 || out_bit !== last_bit) begin
                    errors++;
                    $display("FAIL idle_hold fd=%0b bit=%0b required fd=0 bit=%0b",
                             frame_done, out_bit, last_bit);
                end
            end
            last_bit = out_bit;
        end
    end

    typedef struct {
        logic [8:0] bits;
        logic       mode;
        logic       exp;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int fd_cyc[$];
        vecs[0] = '{9'b111101111, 1'b0, 1'b0};
        vecs[1] = '{9'b111101111, 1'b1, 1'b1};
        vecs[2] = '{9'b111111111, 1'b0, 1'b1};
        vecs[3] = '{9'b000000000, 1'b1, 1'b0};
        vecs[4] = '{9'b000010000, 1'b1, 1'b1};
        vecs[5] = '{9'b000010000, 1'b0, 1'b0};
        vecs[6] = '{9'b111111110, 1'b0, 1'b0};
        vecs[7] = '{9'b100000000, 1'b1, 1'b1};

        @(negedge sys_clk);
        do_reset();

        // Single interior window at col 3, row 1 under each mode.
        for (int i = 0; i < 8; i++) begin
            for (int p = 0; p < 11; p++) drive(9'h1ff, vecs[i].mode);
            drive(vecs[i].bits, ~vecs[i].mode);
            idle(1);
            check("vec_out_en", {31'd0, out_en}, 1);
            check("vec_out_bit", {31'd0, out_bit}, {31'd0, vecs[i].exp});
            drain();
            @(negedge sys_clk);
            do_reset();
        end

        // All-ones erode frame.
        n_en = 0; n_one = 0; n_fd = 0;
        for (int p = 0; p < NPIX; p++) drive(9'h1ff, 1'b0);
        drain();
        check("ones_en_count", n_en, 32);
        check("ones_interior", n_one, 12);
        check("ones_fd_count", n_fd, 1);

        // Mode change mid-frame only takes hold at the next frame.
        for (int p = 0; p < 2*NPIX; p++)
            drive(9'($urandom), (p >= 10) ? 1'b1 : 1'b0);
        drain();

        // Random gaps across three frames, random mode per frame.
        n_en = 0;
        for (int p = 0; p < 3*NPIX; p++) begin
            drive(9'($urandom), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 5));
        end
        drain();
        check("gap_en_count", n_en, 3*NPIX);

        // Reset at pixel 17 discards in-flight results and restarts the frame.
        for (int p = 0; p < 17; p++) drive(9'($urandom), 1'b1);
        do_reset();
        n_fd = 0; n_en = 0;
        for (int p = 0; p < NPIX; p++) drive(9'($urandom), 1'b0);
        drain();
        check("post_rst_fd", n_fd, 1);
        check("post_rst_en", n_en, 32);

        // Continuous frames: frame_done spacing must be exactly 32 cycles.
        n_en = 0;
        fork
            begin
                for (int p = 0; p < 3*NPIX; p++) drive(9'($urandom), 1'($urandom_range(0, 1)));
            end
            begin
                for (int k = 0; k < 3*NPIX + 6; k++) begin
                    @(negedge sys_clk);
                    if (frame_done) fd_cyc.push_back(int'(cyc));
                end
            end
        join
        drain();
        check("b2b_fd_count", fd_cyc.size(), 3);
        check("b2b_en_count", n_en, 3*NPIX);
        if (fd_cyc.size() == 3) begin
            check("b2b_fd_gap1", fd_cyc[1] - fd_cyc[0], 32);
            check("b2b_fd_gap2", fd_cyc[2] - fd_cyc[1], 32);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bin_morph_3x3.md
BIN_MORPH_3X3 -- requirements
Module: bin_morph_3x3

Interface
Parameters:
REQ-001 The block SHALL have parameter IMG_W, default 800: active pixels per line.
REQ-002 The block SHALL have parameter IMG_H, default 480: active lines per frame.
REQ-003 The block SHALL have parameter BORDER_VAL, default 1'b0: output value forced on frame-border pixels.

Ports:
REQ-004 The block SHALL have port sys_clk, input, 1 bit: clock; all logic on the rising edge.
REQ-005 The block SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port matrix_wr_en, input, 1 bit: the 3x3 window is valid this cycle.
REQ-007 The block SHALL have ports matrix_p11..matrix_p33, input, 1 bit each: the 3x3 binary window; p22 is the centre, p1x the oldest row.
REQ-008 The block SHALL have port mode_sel, input, 1 bit: 0 = erode, 1 = dilate.
REQ-009 The block SHALL have port out_en, output, 1 bit: out_bit is valid this cycle.
REQ-010 The block SHALL have port out_bit, output, 1 bit: the morphology result for the pixel.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse with the last pixel of a frame.

Function
REQ-012 A window SHALL be accepted on every rising edge where matrix_wr_en = 1; no backpressure; gaps of any length between accepted windows SHALL be allowed.
REQ-013 Erode result SHALL be the AND of all nine window bits; dilate result SHALL be the OR of all nine window bits.
REQ-014 The block SHALL use a 2-stage pipeline: stage 1 registers the AND/OR results, the border flag, the last-pixel flag and valid; stage 2 registers out_bit, out_en and frame_done.
REQ-015 out_en SHALL assert exactly 2 cycles after the cycle in which the window is accepted, for exactly one cycle per accepted window.
REQ-016 out_bit SHALL hold its last value while out_en = 0.
REQ-017 The block SHALL keep internal counters col (0..IMG_W-1) and row (0..IMG_H-1), each sized to clog2 of its maximum, giving the position of the accepted window's centre pixel.
REQ-018 col SHALL increment on each accepted window; at IMG_W-1 it SHALL wrap to 0 and row SHALL increment.
REQ-019 When col = IMG_W-1 and row = IMG_H-1 on an accepted window, both counters SHALL wrap to 0, and frame_done SHALL pulse coincident with that pixel's out_en.
REQ-020 A pixel SHALL be a border pixel when col = 0, col = IMG_W-1, row = 0 or row = IMG_H-1; its out_bit SHALL be BORDER_VAL regardless of the window contents or the mode.
REQ-021 mode_sel SHALL be latched into an internal register mode_q when the window at col = 0, row = 0 is accepted, and that window SHALL itself use the new value.
REQ-022 mode_q SHALL be constant for the rest of the frame; changes to mode_sel mid-frame SHALL take effect only at the next frame's first pixel.
REQ-023 No output SHALL depend combinationally on any input.

Reset
REQ-024 While sys_rst_n = 0: out_en, out_bit and frame_done SHALL be 0; col, row and mode_q SHALL be 0; all pipeline valid bits SHALL be 0.
REQ-025 Reset asserted mid-frame SHALL discard in-flight pixels, with no out_en after reset assertion.
REQ-026 The first window accepted after reset deassertion SHALL be treated as col = 0, row = 0.

Verification (bench with IMG_W = 8, IMG_H = 4, BORDER_VAL = 0)
REQ-027 All-ones frame with mode_sel = 0: 32 out_en pulses; out_bit = 1 only at interior pixels (rows 1-2, cols 1-6, 12 pixels); frame_done on the 32nd pulse only.
REQ-028 Single window 9'b111101111 at col = 3, row = 1: erode gives out_bit = 0; dilate gives out_bit = 1; out_en is exactly 2 cycles after acceptance.
REQ-029 Random gaps of 0-5 idle cycles between windows: out_en count equals the accepted count; per-pixel results match the reference model; col/row wrap correctly across 3 consecutive frames.
REQ-030 mode_sel toggled at pixel 10 of frame 0: the whole of frame 0 uses the erode result; frame 1 uses the dilate result.
REQ-031 sys_rst_n pulsed low at pixel 17: outputs go to 0 immediately; no stale out_en; the next frame starts at col 0, row 0 and frame_done arrives after exactly 32 more windows.
REQ-032 Back-to-back frames with continuous matrix_wr_en = 1: frame_done pulses every 32 cycles with no dropped or duplicated out_en.
